fa_ramp_ctrl: RTL and testbench

Parametrised frequency/amplitude setpoint controller for the rocking drive. It holds the F (rocking frequency) and A (swing amplitude) setpoints and steps them on user/sensor commands, with saturation at configurable limits and a rate-limit hold-off between accepted steps. When F reaches zero, or a stop is requested, it decays A automatically to zero. Its outputs feed the motor-drive and display blocks.

---
 rtl/fa_ramp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fa_ramp_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_ramp_ctrl.sv
// fa_ramp_ctrl: F/A setpoint stepper with saturation, step hold-off,
// stop request and automatic amplitude decay down to STOPPED.
//
// Ports:
//   clk      - clock, all state updates on the falling edge
//   reset    - asynchronous, active-high
//   f_up     - request F+1
//   f_down   - request F-1
//   a_up     - request A+1
//   a_down   - request A-1
//   stop     - force F to 0, then let A decay
//   F, A     - registered setpoints
//   F0, A0   - F == 0, A == 0 (combinational)
//   hold     - hold-off active, commands ignored
//   stopped  - high in STOPPED
//   evt      - one-edge pulse when F or A changed
module fa_ramp_ctrl #(
    parameter int W         = 3,
    parameter int F_MAX     = 7,
    parameter int A_MAX     = 7,
    parameter int F_INIT    = 5,
    parameter int A_INIT    = 5,
    parameter int HOLD      = 4,
    parameter int DECAY_DIV = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         f_up,
    input  logic         f_down,
    input  logic         a_up,
    input  logic         a_down,
    input  logic         stop,
    output logic [W-1:0] F,
    output logic [W-1:0] A,
    output logic         F0,
    output logic         A0,
    output logic         hold,
    output logic         stopped,
    output logic         evt
);

    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    localparam logic [W-1:0]  FMAX  = W'(F_MAX);
    localparam logic [W-1:0]  AMAX  = W'(A_MAX);
    localparam logic [W-1:0]  FRST  = W'(F_INIT);
    localparam logic [W-1:0]  ARST  = W'(A_INIT);
    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [HW-1:0] HLOAD = HW'(HOLD);
    localparam logic [DW-1:0] DLOAD = DW'(DECAY_DIV - 1);

    typedef enum logic [1:0] {
        RUN,
        DECAY,
        STOPPED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  f_nxt;
    logic [W-1:0]  a_nxt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic          evt_nxt;

    logic f_inc;
    logic f_dec;
    logic a_inc;
    logic a_dec;
    logic step;

    // Opposite requests on the same axis cancel each other.
    assign f_inc = f_up & ~f_down;
    assign f_dec = f_down & ~f_up;
    assign a_inc = a_up & ~a_down;
    assign a_dec = a_down & ~a_up;
    assign step  = f_inc | f_dec | a_inc | a_dec;

    assign F0      = (F == '0);
    assign A0      = (A == '0);
    assign hold    = (hcnt != '0);
    assign stopped = (state == STOPPED);

    always_comb begin
        state_nxt = state;
        f_nxt     = F;
        a_nxt     = A;
        dcnt_nxt  = dcnt;
        hcnt_nxt  = hcnt;
        if (hcnt != '0) begin
            hcnt_nxt = hcnt - HW'(1);
        end

        unique case (state)
            RUN: begin
                // Primed so the first decrement lands
                // DECAY_DIV edges after entering DECAY.
                dcnt_nxt = DLOAD;
                if (stop) begin
                    f_nxt = '0;
                    if (A != '0) begin
                        state_nxt = DECAY;
                    end else begin
                        state_nxt = STOPPED;
                    end
                end else if (!hold && step) begin
                    hcnt_nxt = HLOAD;
                    if (f_inc && F != FMAX && F != '0) begin
                        f_nxt = F + ONE;
                    end
                    if (f_dec && F != '0) begin
                        f_nxt = F - ONE;
                    end
                    if (a_inc && A != AMAX) begin
                        a_nxt = A + ONE;
                    end
                    if (a_dec && A != '0) begin
                        a_nxt = A - ONE;
                    end
                    if (f_nxt == '0) begin
                        if (a_nxt != '0) begin
                            state_nxt = DECAY;
                        end else begin
                            state_nxt = STOPPED;
                        end
                    end
                end
            end
            DECAY: begin
                f_nxt = '0;
                if (dcnt == '0) begin
                    dcnt_nxt = DLOAD;
                    if (A != '0) begin
                        a_nxt = A - ONE;
                    end
                    if (a_nxt == '0) begin
                        state_nxt = STOPPED;
                    end
                end else begin
                    dcnt_nxt = dcnt - DW'(1);
                end
            end
            STOPPED: begin
                f_nxt = '0;
                a_nxt = '0;
            end
            default: begin
                state_nxt = STOPPED;
                f_nxt     = '0;
                a_nxt     = '0;
            end
        endcase

        evt_nxt = (f_nxt != F) || (a_nxt != A);
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            F     <= FRST;
            A     <= ARST;
            hcnt  <= '0;
            dcnt  <= DLOAD;
            evt   <= 1'b0;
        end else begin
            state <= state_nxt;
            F     <= f_nxt;
            A     <= a_nxt;
            hcnt  <= hcnt_nxt;
            dcnt  <= dcnt_nxt;
            evt   <= evt_nxt;
        end
    end

endmodule

// File: tb/tb_fa_ramp_ctrl.sv
// tb_fa_ramp_ctrl: directed stimulus for fa_ramp_ctrl with a
// scoreboard queue drained by a falling-edge monitor.
module tb_fa_ramp_ctrl;

    logic       clk;
    logic       reset;
    logic       f_up;
    logic       f_down;
    logic       a_up;
    logic       a_down;
    logic       stop;
    logic [2:0] F;
    logic [2:0] A;
    logic       F0;
    logic       A0;
    logic       hold;
    logic       stopped;
    logic       evt;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] f;
        logic [2:0] a;
        logic       h;
        logic       s;
        logic       e;
        logic       ch;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t it;

    fa_ramp_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .f_up    (f_up),
        .f_down  (f_down),
        .a_up    (a_up),
        .a_down  (a_down),
        .stop    (stop),
        .F       (F),
        .A       (A),
        .F0      (F0),
        .A0      (A0),
        .hold    (hold),
        .stopped (stopped),
        .evt     (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act,
                         input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    // Monitor: one expectation per falling edge while items queued.
    always @(negedge clk) begin
        #1;
        if (!reset && q.size() != 0) begin
            it = q.pop_front();
            check({it.nm, ".F"}, int'(F), int'(it.f));
            check({it.nm, ".A"}, int'(A), int'(it.a));
            check({it.nm, ".F0"}, int'(F0), int'(it.f == 3'd0));
            check({it.nm, ".A0"}, int'(A0), int'(it.a == 3'd0));
            check({it.nm, ".stopped"}, int'(stopped), int'(it.s));
            check({it.nm, ".evt"}, int'(evt), int'(it.e));
            if (it.ch) begin
                check({it.nm, ".hold"}, int'(hold), int'(it.h));
            end
        end
    end

    task automatic cyc(input logic fu, input logic fd,
                       input logic au, input logic ad,
                       input logic st,
                       input logic [2:0] ef, input logic [2:0] ea,
                       input logic eh, input logic es,
                       input logic ee, input logic ec,
                       input string nm);
        exp_t x;
        @(posedge clk);
        f_up   = fu;
        f_down = fd;
        a_up   = au;
        a_down = ad;
        stop   = st;
        x.f  = ef;
        x.a  = ea;
        x.h  = eh;
        x.s  = es;
        x.e  = ee;
        x.ch = ec;
        x.nm = nm;
        q.push_back(x);
    endtask

    // One command edge, then four idle edges covering the hold-off.
    task automatic pulse(input logic fu, input logic fd,
                         input logic au, input logic ad,
                         input logic st,
                         input logic [2:0] ef, input logic [2:0] ea,
                         input logic es, input logic ee,
                         input logic ec, input string nm);
        cyc(fu, fd, au, ad, st, ef, ea, 1'b1, es, ee, ec, nm);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, ef, ea, 1'b1, es, 1'b0, ec, nm);
        end
        cyc(0, 0, 0, 0, 0, ef, ea, 1'b0, es, 1'b0, ec, nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0",
                     q.size());
            q.delete();
        end
        f_up   = 1'b0;
        f_down = 1'b0;
        a_up   = 1'b0;
        a_down = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        drain();
        #2;
        reset = 1'b1;
        #1;
        check({nm, ".F"}, int'(F), 5);
        check({nm, ".A"}, int'(A), 5);
        check({nm, ".hold"}, int'(hold), 0);
        check({nm, ".stopped"}, int'(stopped), 0);
        check({nm, ".evt"}, int'(evt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        f_up   = 1'b0;
        f_down = 1'b0;
        a_up   = 1'b0;
        a_down = 1'b0;
        stop   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst0.F", int'(F), 5);
        check("rst0.A", int'(A), 5);
        check("rst0.hold", int'(hold), 0);
        check("rst0.stopped", int'(stopped), 0);
        reset = 1'b0;

        // f_up held: F=6 at edge 1, 7 at edge 6, saturates after.
        for (int k = 1; k <= 12; k++) begin
            cyc(1, 0, 0, 0, 0, (k < 6) ? 3'd6 : 3'd7, 3'd5,
                ((k - 1) % 5) != 4, 1'b0,
                (k == 1) || (k == 6), 1'b1, "fup_hold");
        end
        for (int k = 13; k <= 15; k++) begin
            cyc(0, 0, 0, 0, 0, 3'd7, 3'd5, k < 15, 1'b0,
                1'b0, 1'b1, "fup_drain");
        end
        pulse(0, 0, 0, 1, 0, 3'd7, 3'd4, 0, 1, 1, "a_dn1");
        pulse(0, 0, 0, 1, 0, 3'd7, 3'd3, 0, 1, 1, "a_dn2");
        pulse(0, 0, 0, 1, 0, 3'd7, 3'd2, 0, 1, 1, "a_dn3");
        do_reset("rst_mid");

        // Cancelling pairs, A saturation, joint F/A step.
        cyc(1, 1, 0, 0, 0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1,
            "f_cancel");
        cyc(0, 0, 1, 1, 0, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1,
            "a_cancel");
        pulse(0, 0, 1, 0, 0, 3'd5, 3'd6, 0, 1, 1, "a_up1");
        pulse(0, 0, 1, 0, 0, 3'd5, 3'd7, 0, 1, 1, "a_up2");
        pulse(0, 0, 1, 0, 0, 3'd5, 3'd7, 0, 0, 1, "a_sat");
        pulse(1, 0, 0, 1, 0, 3'd6, 3'd6, 0, 1, 1, "fa_both");
        do_reset("rst_b");

        // f_down to zero enters DECAY; commands ignored there.
        pulse(0, 1, 0, 0, 0, 3'd4, 3'd5, 0, 1, 1, "f_dn1");
        pulse(0, 1, 0, 0, 0, 3'd3, 3'd5, 0, 1, 1, "f_dn2");
        pulse(0, 1, 0, 0, 0, 3'd2, 3'd5, 0, 1, 1, "f_dn3");
        pulse(0, 1, 0, 0, 0, 3'd1, 3'd5, 0, 1, 1, "f_dn4");
        pulse(0, 1, 0, 0, 0, 3'd0, 3'd5, 0, 1, 1, "f_to0");
        for (int k = 26; k <= 64; k++) begin
            cyc(1, 0, 1, 0, 1, 3'd0,
                (k >= 61) ? 3'd0 : 3'(5 - (k - 21) / 8),
                1'b0, k >= 61,
                (k == 29) || (k == 37) || (k == 45) ||
                (k == 53) || (k == 61),
                1'b1, "decay");
        end
        do_reset("rst_c");

        // A to zero by steps, then stop goes straight to STOPPED.
        pulse(0, 0, 0, 1, 0, 3'd5, 3'd4, 0, 1, 1, "a_z1");
        pulse(0, 0, 0, 1, 0, 3'd5, 3'd3, 0, 1, 1, "a_z2");
        pulse(0, 0, 0, 1, 0, 3'd5, 3'd2, 0, 1, 1, "a_z3");
        pulse(0, 0, 0, 1, 0, 3'd5, 3'd1, 0, 1, 1, "a_z4");
        pulse(0, 0, 0, 1, 0, 3'd5, 3'd0, 0, 1, 1, "a_z5");
        pulse(0, 0, 0, 0, 1, 3'd0, 3'd0, 1, 1, 0, "stop_a0");
        pulse(1, 0, 1, 0, 0, 3'd0, 3'd0, 1, 0, 0, "stp_ign");
        do_reset("rst_d");

        // stop beats a_up during hold-off; decay every 8 edges.
        cyc(0, 1, 0, 0, 0, 3'd4, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1,
            "pre_stop");
        cyc(0, 0, 1, 0, 1, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0,
            "stop_hold");
        for (int k = 3; k <= 18; k++) begin
            cyc(0, 0, 0, 0, 0, 3'd0,
                (k < 10) ? 3'd5 : ((k < 18) ? 3'd4 : 3'd3),
                1'b0, 1'b0, (k == 10) || (k == 18), 1'b0,
                "decay8");
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
